// File: rtl/uart_rx_frame_chk_pkg.sv
// Shared UART definitions: RX frame FSM encoding, parity-type encoding and the
// parity rule used by both the TX generator and the RX checker.
package uart_rx_frame_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } par_typ_t;

   typedef struct packed {
      logic     par_en;
      par_typ_t par_typ;
   } frame_cfg_t;

   // Parity bit a transmitter appends for a given XOR-reduction of the data.
   function automatic logic parity_bit(input logic run_par, input par_typ_t par_typ);
      return (par_typ == PAR_ODD) ? ~run_par : run_par;
   endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// LSB-first deserializer with bit counter and running XOR parity, controlled
// by the frame FSM through clr/load.
module uart_rx_deser #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic                  bit_in,
   output logic [DATA_WIDTH-1:0] shreg,
   output logic                  run_par,
   output logic                  last_c
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         run_par <= 1'b0;
         cnt     <= '0;
      end else if (clr) begin
         shreg   <= '0;
         run_par <= 1'b0;
         cnt     <= '0;
      end else if (load) begin
         shreg   <= {bit_in, shreg[DATA_WIDTH-1:1]};
         run_par <= run_par ^ bit_in;
         cnt     <= cnt + CNT_W'(1);
      end
   end

   // High while the bit being loaded is the final data bit of the word.
   assign last_c = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker: tracks start/data/parity/stop from strobed bits and
// reports a valid word or a start, parity or stop error one cycle after the last strobe.
module uart_rx_frame_chk
   import uart_rx_frame_chk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  Frame_Start,
   input  logic                  Bit_Strb,
   input  logic                  Sampled_Bit,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err,
   output logic                  Strt_Err,
   output logic                  Busy
);

   rx_state_t             state, state_nxt;
   frame_cfg_t            cfg, cfg_nxt;
   logic                  par_mis, par_mis_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  dv_nxt, pe_nxt, se_nxt, ste_nxt, busy_nxt;
   logic                  clr_c, load_c;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  run_par;
   logic                  last_c;

   uart_rx_deser #(.DATA_WIDTH(DATA_WIDTH)) u_deser (
      .clk     (CLK),
      .rst_n   (RST),
      .clr     (clr_c),
      .load    (load_c),
      .bit_in  (Sampled_Bit),
      .shreg   (shreg),
      .run_par (run_par),
      .last_c  (last_c)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         cfg        <= '0;
         par_mis    <= 1'b0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stp_Err    <= 1'b0;
         Strt_Err   <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cfg        <= cfg_nxt;
         par_mis    <= par_mis_nxt;
         P_DATA     <= data_nxt;
         Data_Valid <= dv_nxt;
         Par_Err    <= pe_nxt;
         Stp_Err    <= se_nxt;
         Strt_Err   <= ste_nxt;
         Busy       <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cfg_nxt     = cfg;
      par_mis_nxt = par_mis;
      data_nxt    = P_DATA;
      dv_nxt      = 1'b0;
      pe_nxt      = 1'b0;
      se_nxt      = 1'b0;
      ste_nxt     = 1'b0;
      clr_c       = 1'b0;
      load_c      = 1'b0;
      case (state)
         // Strobes in IDLE are dropped; config is frozen for the whole frame.
         ST_IDLE: begin
            if (Frame_Start) begin
               state_nxt   = ST_START;
               cfg_nxt     = '{par_en: PAR_EN, par_typ: par_typ_t'(PAR_TYP)};
               par_mis_nxt = 1'b0;
               clr_c       = 1'b1;
            end
         end
         ST_START: begin
            if (Bit_Strb) begin
               if (Sampled_Bit) begin
                  ste_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (Bit_Strb) begin
               load_c = 1'b1;
               if (last_c) state_nxt = cfg.par_en ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (Bit_Strb) begin
               par_mis_nxt = (Sampled_Bit != parity_bit(run_par, cfg.par_typ));
               state_nxt   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (Bit_Strb) begin
               state_nxt = ST_IDLE;
               se_nxt    = ~Sampled_Bit;
               pe_nxt    = par_mis;
               if (Sampled_Bit && !par_mis) begin
                  dv_nxt   = 1'b1;
                  data_nxt = shreg;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Randomized self-checking bench for uart_rx_frame_chk against a frame-level
// reference model (outcome computed from the whole frame's bit list).
module tb_uart_rx_frame_chk;

   localparam int unsigned DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic          Frame_Start = 1'b0;
   logic          Bit_Strb = 1'b0;
   logic          Sampled_Bit = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid, Par_Err, Stp_Err, Strt_Err, Busy;
   logic [3:0]    pulses;

   int            n_checks = 0;
   int            n_errs   = 0;
   logic [DW-1:0] model_pdata = '0;

   uart_rx_frame_chk #(.DATA_WIDTH(DW)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .Frame_Start (Frame_Start),
      .Bit_Strb    (Bit_Strb),
      .Sampled_Bit (Sampled_Bit),
      .P_DATA      (P_DATA),
      .Data_Valid  (Data_Valid),
      .Par_Err     (Par_Err),
      .Stp_Err     (Stp_Err),
      .Strt_Err    (Strt_Err),
      .Busy        (Busy)
   );

   always #5 CLK = ~CLK;

   assign pulses = {Data_Valid, Par_Err, Stp_Err, Strt_Err};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Frame outcome {Data_Valid, Par_Err, Stp_Err, Strt_Err} from the UART rules.
   function automatic logic [3:0] model_frame(input logic [DW-1:0] d, input logic pen,
                                              input logic ptyp, input logic pbit,
                                              input logic sbit, input logic stp);
      int   ones;
      logic want, pe, se;
      if (sbit) return 4'b0001;
      ones = 0;
      for (int i = 0; i < int'(DW); i++) ones += int'(d[i]);
      want = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
      pe   = pen && (pbit != want);
      se   = !stp;
      return {!(pe || se), pe, se, 1'b0};
   endfunction

   task automatic run_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic stp,
                            input int gap_max, input bit junk, input bit same_strb);
      logic       q[$];
      int         nstrb;
      logic [3:0] exp;
      q.push_back(sbit);
      for (int i = 0; i < int'(DW); i++) q.push_back(d[i]);
      if (pen) q.push_back(pbit);
      q.push_back(stp);
      nstrb = sbit ? 1 : q.size();

      Frame_Start = 1'b1;
      PAR_EN      = pen;
      PAR_TYP     = ptyp;
      Bit_Strb    = same_strb;
      Sampled_Bit = 1'($urandom);
      tick();
      Frame_Start = 1'b0;
      Bit_Strb    = 1'b0;
      check("busy_start", 32'({Busy, pulses}), 32'(5'b10000));

      for (int k = 0; k < nstrb; k++) begin
         for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
            Sampled_Bit = 1'($urandom);
            if (junk) begin
               PAR_EN      = 1'($urandom);
               PAR_TYP     = ~PAR_TYP;
               Frame_Start = 1'($urandom);
            end
            tick();
            Frame_Start = 1'b0;
            check("gap_quiet", 32'({Busy, pulses}), 32'(5'b10000));
         end
         Bit_Strb    = 1'b1;
         Sampled_Bit = q[k];
         if (junk) begin
            PAR_EN      = 1'($urandom);
            PAR_TYP     = ~PAR_TYP;
            Frame_Start = 1'b1;
         end
         tick();
         Bit_Strb    = 1'b0;
         Frame_Start = 1'b0;
         if (k < nstrb - 1) begin
            check("mid_frame", 32'({Busy, pulses}), 32'(5'b10000));
         end else begin
            exp = model_frame(d, pen, ptyp, pbit, sbit, stp);
            if (exp[3]) model_pdata = d;
            check("frame_flags", 32'({Busy, pulses}), 32'({1'b0, exp}));
            check("p_data", 32'(P_DATA), 32'(model_pdata));
         end
      end
      tick();
      check("pulse_width", 32'({Busy, pulses}), 32'(0));
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          pen, ptyp, pbit, want;

      RST = 1'b0;
      tick();
      tick();
      check("reset_flags", 32'({Busy, pulses}), 32'(0));
      check("reset_pdata", 32'(P_DATA), 32'(0));
      RST = 1'b1;
      tick();

      // Directed frames.
      run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1);
      run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      run_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
      run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);

      // Reset after four data bits aborts silently.
      Frame_Start = 1'b1;
      PAR_EN      = 1'b1;
      PAR_TYP     = 1'b0;
      tick();
      Frame_Start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         Bit_Strb    = 1'b1;
         Sampled_Bit = (k != 0);
         tick();
         Bit_Strb = 1'b0;
      end
      #2;
      RST = 1'b0;
      #1;
      model_pdata = '0;
      check("rst_mid_flags", 32'({Busy, pulses}), 32'(0));
      check("rst_mid_pdata", 32'(P_DATA), 32'(0));
      tick();
      RST = 1'b1;
      tick();
      check("rst_after", 32'({Busy, pulses}), 32'(0));
      run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);

      // Consecutive-cycle strobes with config churn and stray Frame_Start.
      run_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      run_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0);

      // Randomized frames.
      for (int n = 0; n < 80; n++) begin
         d    = DW'($urandom);
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
         want = ptyp ? ~(^d) : (^d);
         pbit = ($urandom_range(3, 0) == 0) ? ~want : want;
         run_frame(d, pen, ptyp, pbit,
                   ($urandom_range(9, 0) == 0),
                   ($urandom_range(6, 0) != 0),
                   $urandom_range(2, 0), 1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
